// File: rtl/input_mems_pkg.sv
// Shared types and sizing for the ping-pong A/B input loader.
// Address widths are derived from the matrix dimensions.
package input_mems_pkg;

    localparam int unsigned INW  = 12;
    localparam int unsigned M    = 7;
    localparam int unsigned N    = 9;
    localparam int unsigned MAXK = 8;

    localparam int unsigned K_BITS      = $clog2(MAXK + 1);
    localparam int unsigned A_DEPTH     = M * MAXK;
    localparam int unsigned B_DEPTH     = MAXK * N;
    localparam int unsigned A_ADDR_BITS = $clog2(A_DEPTH);
    localparam int unsigned B_ADDR_BITS = $clog2(B_DEPTH);
    localparam int unsigned CNT_BITS    = (A_ADDR_BITS > B_ADDR_BITS) ? A_ADDR_BITS : B_ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_A,
        LOAD_B
    } load_state_t;

    typedef struct packed {
        logic              a_bank;
        logic              b_bank;
        logic [K_BITS-1:0] k;
    } set_desc_t;

    // K of zero would describe an empty matrix; oversized K cannot fit the banks.
    function automatic logic [K_BITS-1:0] clamp_k(input logic [K_BITS-1:0] k_raw);
        if (k_raw == '0) begin
            return K_BITS'(1);
        end
        if (k_raw > K_BITS'(MAXK)) begin
            return K_BITS'(MAXK);
        end
        return k_raw;
    endfunction

endpackage

// File: rtl/input_mems_pingpong_mem.sv
// Single-port synchronous RAM bank: one write or read address per cycle,
// registered read data cleared by reset.
module input_mems_pingpong_mem #(
    parameter int unsigned Width    = 12,
    parameter int unsigned Depth    = 56,
    parameter int unsigned AddrBits = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                we_i,
    input  logic [AddrBits-1:0] addr_i,
    input  logic [Width-1:0]    wdata_i,
    output logic [Width-1:0]    rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/input_mems_pingpong.sv
// Double-buffered A/B matrix loader: streams a set into free banks while the
// compute engine reads the head set, with a 2-entry queue of loaded sets.
module input_mems_pingpong
    import input_mems_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [INW-1:0]          AXIS_TDATA,
    input  logic                    AXIS_TVALID,
    input  logic [K_BITS:0]         AXIS_TUSER,
    output logic                    AXIS_TREADY,
    output logic                    matrices_loaded,
    input  logic                    compute_finished,
    output logic [K_BITS-1:0]       K,
    input  logic [A_ADDR_BITS-1:0]  A_read_addr,
    output logic signed [INW-1:0]   A_data,
    input  logic [B_ADDR_BITS-1:0]  B_read_addr,
    output logic signed [INW-1:0]   B_data
);

    load_state_t         state_q, state_d;
    logic [CNT_BITS-1:0] wr_addr_q, wr_addr_d;
    set_desc_t           cur_q, cur_d;
    logic                last_a_q, last_a_d;

    set_desc_t           q_mem_q [2];
    logic                head_q, head_d;
    logic [1:0]          count_q, count_d;
    logic                tail;

    logic                ml_q, ml_d;
    logic                tready_q;
    logic [K_BITS-1:0]   k_q, k_d;
    logic                rd_a_bank_q, rd_a_bank_d, rd_b_bank_q, rd_b_bank_d;
    logic                a_sel_q, b_sel_q;
    set_desc_t           nxt_head;

    logic                beat, pop, commit;
    logic                have_head, free_a, free_b;
    logic                a_we, b_we, wr_bank_a, wr_bank_b;
    logic [CNT_BITS-1:0] a_last, b_last;
    logic [1:0]          a_we_bank, b_we_bank;
    logic [A_ADDR_BITS-1:0] a_addr [2];
    logic [B_ADDR_BITS-1:0] b_addr [2];
    logic [INW-1:0]      a_rdata [2];
    logic [INW-1:0]      b_rdata [2];

    assign beat      = AXIS_TVALID && tready_q;
    assign pop       = compute_finished && ml_q;
    assign have_head = (count_q != 2'd0);
    assign free_a    = have_head ? ~q_mem_q[head_q].a_bank : 1'b0;
    assign free_b    = have_head ? ~q_mem_q[head_q].b_bank : 1'b0;
    assign a_last    = CNT_BITS'(M * cur_q.k - 1);
    assign b_last    = CNT_BITS'(cur_q.k * N - 1);

    // Loader FSM: first beat of a set latches TUSER and writes word 0.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        cur_d     = cur_q;
        last_a_d  = last_a_q;
        commit    = 1'b0;
        a_we      = 1'b0;
        b_we      = 1'b0;
        wr_bank_a = cur_q.a_bank;
        wr_bank_b = cur_q.b_bank;
        unique case (state_q)
            IDLE: begin
                if (beat) begin
                    cur_d.k      = clamp_k(AXIS_TUSER[K_BITS:1]);
                    cur_d.b_bank = free_b;
                    wr_addr_d    = CNT_BITS'(1);
                    if (AXIS_TUSER[0]) begin
                        cur_d.a_bank = free_a;
                        last_a_d     = free_a;
                        wr_bank_a    = free_a;
                        a_we         = 1'b1;
                        state_d      = LOAD_A;
                    end else begin
                        cur_d.a_bank = last_a_q;
                        wr_bank_b    = free_b;
                        b_we         = 1'b1;
                        state_d      = LOAD_B;
                    end
                end
            end
            LOAD_A: begin
                if (beat) begin
                    a_we = 1'b1;
                    if (wr_addr_q == a_last) begin
                        state_d   = LOAD_B;
                        wr_addr_d = '0;
                    end else begin
                        wr_addr_d = wr_addr_q + CNT_BITS'(1);
                    end
                end
            end
            LOAD_B: begin
                if (beat) begin
                    b_we = 1'b1;
                    if (wr_addr_q == b_last) begin
                        commit    = 1'b1;
                        state_d   = IDLE;
                        wr_addr_d = '0;
                    end else begin
                        wr_addr_d = wr_addr_q + CNT_BITS'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bank port muxing: the bank being written takes the write counter.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            a_we_bank[b] = a_we && (wr_bank_a == b[0]) && (wr_addr_q < CNT_BITS'(A_DEPTH));
            b_we_bank[b] = b_we && (wr_bank_b == b[0]) && (wr_addr_q < CNT_BITS'(B_DEPTH));
            a_addr[b]    = a_we_bank[b] ? wr_addr_q[A_ADDR_BITS-1:0] : A_read_addr;
            b_addr[b]    = b_we_bank[b] ? wr_addr_q[B_ADDR_BITS-1:0] : B_read_addr;
        end
    end

    // Queue update; a set committed into the new head slot is bypassed to the outputs.
    always_comb begin
        tail        = head_q ^ count_q[0];
        count_d     = count_q + 2'(commit) - 2'(pop);
        head_d      = head_q ^ pop;
        nxt_head    = (commit && (tail == head_d)) ? cur_q : q_mem_q[head_d];
        ml_d        = (count_d != 2'd0) && !pop;
        k_d         = k_q;
        rd_a_bank_d = rd_a_bank_q;
        rd_b_bank_d = rd_b_bank_q;
        if (count_d != 2'd0) begin
            k_d         = nxt_head.k;
            rd_a_bank_d = nxt_head.a_bank;
            rd_b_bank_d = nxt_head.b_bank;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            cur_q       <= '0;
            last_a_q    <= 1'b0;
            head_q      <= 1'b0;
            count_q     <= 2'd0;
            ml_q        <= 1'b0;
            tready_q    <= 1'b0;
            k_q         <= '0;
            rd_a_bank_q <= 1'b0;
            rd_b_bank_q <= 1'b0;
            a_sel_q     <= 1'b0;
            b_sel_q     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            cur_q       <= cur_d;
            last_a_q    <= last_a_d;
            head_q      <= head_d;
            count_q     <= count_d;
            ml_q        <= ml_d;
            tready_q    <= (count_d < 2'd2);
            k_q         <= k_d;
            rd_a_bank_q <= rd_a_bank_d;
            rd_b_bank_q <= rd_b_bank_d;
            a_sel_q     <= rd_a_bank_q;
            b_sel_q     <= rd_b_bank_q;
            if (commit) begin
                q_mem_q[tail] <= cur_q;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        input_mems_pingpong_mem #(
            .Width    (INW),
            .Depth    (A_DEPTH),
            .AddrBits (A_ADDR_BITS)
        ) u_a_mem (
            .clk_i   (clk),
            .rst_ni  (reset),
            .we_i    (a_we_bank[g]),
            .addr_i  (a_addr[g]),
            .wdata_i (AXIS_TDATA),
            .rdata_o (a_rdata[g])
        );

        input_mems_pingpong_mem #(
            .Width    (INW),
            .Depth    (B_DEPTH),
            .AddrBits (B_ADDR_BITS)
        ) u_b_mem (
            .clk_i   (clk),
            .rst_ni  (reset),
            .we_i    (b_we_bank[g]),
            .addr_i  (b_addr[g]),
            .wdata_i (AXIS_TDATA),
            .rdata_o (b_rdata[g])
        );
    end

    assign AXIS_TREADY     = tready_q;
    assign matrices_loaded = ml_q;
    assign K               = k_q;
    assign A_data          = a_sel_q ? a_rdata[1] : a_rdata[0];
    assign B_data          = b_sel_q ? b_rdata[1] : b_rdata[0];

endmodule

// File: tb/tb_input_mems_pingpong.sv
// Directed bench for the ping-pong loader: loads sets over AXIS, reads banks back,
// and checks queue/handshake timing against hand-computed values.
module tb_input_mems_pingpong;
    import input_mems_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [INW-1:0]         AXIS_TDATA;
    logic                   AXIS_TVALID;
    logic [K_BITS:0]        AXIS_TUSER;
    logic                   AXIS_TREADY;
    logic                   matrices_loaded;
    logic                   compute_finished;
    logic [K_BITS-1:0]      K;
    logic [A_ADDR_BITS-1:0] A_read_addr;
    logic signed [INW-1:0]  A_data;
    logic [B_ADDR_BITS-1:0] B_read_addr;
    logic signed [INW-1:0]  B_data;

    int n_checks = 0;
    int n_fail   = 0;

    input_mems_pingpong dut (
        .clk              (clk),
        .reset            (reset),
        .AXIS_TDATA       (AXIS_TDATA),
        .AXIS_TVALID      (AXIS_TVALID),
        .AXIS_TUSER       (AXIS_TUSER),
        .AXIS_TREADY      (AXIS_TREADY),
        .matrices_loaded  (matrices_loaded),
        .compute_finished (compute_finished),
        .K                (K),
        .A_read_addr      (A_read_addr),
        .A_data           (A_data),
        .B_read_addr      (B_read_addr),
        .B_data           (B_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One beat; returns the number of cycles spent waiting for TREADY.
    task automatic send_beat(input int data, input int user, output int stall_o);
        int waits = 0;
        AXIS_TDATA  = INW'(data);
        AXIS_TUSER  = (K_BITS + 1)'(user);
        AXIS_TVALID = 1'b1;
        @(negedge clk);
        while (!AXIS_TREADY && waits < 300) begin
            waits++;
            @(negedge clk);
        end
        if (waits == 300) begin
            check_val("tready_timeout", int'(AXIS_TREADY), 1);
        end
        @(posedge clk);
        #1;
        AXIS_TVALID = 1'b0;
        stall_o = waits;
    endtask

    task automatic send_set(input int user, input int base, input int first, input int count,
                            input bit gap, output int stalls);
        int s;
        stalls = 0;
        for (int i = first; i < first + count; i++) begin
            send_beat(base + i, user, s);
            stalls += s;
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic read_check(input string tag, input int a_addr, input int b_addr,
                              input int a_exp, input int b_exp);
        @(negedge clk);
        A_read_addr = A_ADDR_BITS'(a_addr);
        B_read_addr = B_ADDR_BITS'(b_addr);
        @(posedge clk);
        #1;
        check_val({tag, "_A"}, int'(A_data), a_exp);
        check_val({tag, "_B"}, int'(B_data), b_exp);
    endtask

    task automatic pulse_cf();
        @(posedge clk);
        #1;
        compute_finished = 1'b1;
        @(posedge clk);
        #1;
        compute_finished = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        reset            = 1'b0;
        AXIS_TVALID      = 1'b0;
        AXIS_TDATA       = '0;
        AXIS_TUSER       = '0;
        compute_finished = 1'b0;
        A_read_addr      = '0;
        B_read_addr      = '0;
        #1;
        check_val("rst_tready", int'(AXIS_TREADY), 0);
        check_val("rst_ml", int'(matrices_loaded), 0);
        check_val("rst_k", int'(K), 0);
        check_val("rst_adata", int'(A_data), 0);
        check_val("rst_bdata", int'(B_data), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: set1 new_A=1 K=2, data 0..31
        send_set(5, 0, 0, 31, 1'b0, s);
        check_val("t1_ml_pre", int'(matrices_loaded), 0);
        send_set(5, 0, 31, 1, 1'b0, s);
        check_val("t1_ml", int'(matrices_loaded), 1);
        check_val("t1_k", int'(K), 2);
        read_check("t1_r0", 3, 17, 3, 31);
        read_check("t1_r1", 13, 0, 13, 14);

        // 2: set2 new_A=0 K=2 loads behind set1; set3 stalls until set1 is popped
        send_set(4, 100, 0, 18, 1'b0, s);
        check_val("t2_no_stall", s, 0);
        check_val("t2_ml", int'(matrices_loaded), 1);
        read_check("t2_set1_kept", 3, 17, 3, 31);
        fork
            send_set(5, 200, 0, 32, 1'b0, s);
            begin
                repeat (3) @(negedge clk);
                check_val("t2_stall", int'(AXIS_TREADY), 0);
                check_val("t2_ml_stall", int'(matrices_loaded), 1);
                pulse_cf();
                check_val("t2_gap", int'(matrices_loaded), 0);
                @(posedge clk);
                #1;
                check_val("t2_ml_after", int'(matrices_loaded), 1);
                check_val("t2_k", int'(K), 2);
                read_check("t2_r0", 3, 0, 3, 100);
                read_check("t2_r1", 0, 17, 0, 117);
            end
        join

        // 3: pop set2, then commit set4 on the same cycle as popping set3
        pulse_cf();
        @(posedge clk);
        #1;
        check_val("t3_ml_set3", int'(matrices_loaded), 1);
        read_check("t3_set3", 3, 0, 203, 214);
        read_check("t3_set3b", 13, 17, 213, 231);
        send_set(4, 300, 0, 17, 1'b0, s);
        AXIS_TDATA       = INW'(317);
        AXIS_TUSER       = (K_BITS + 1)'(4);
        AXIS_TVALID      = 1'b1;
        compute_finished = 1'b1;
        @(negedge clk);
        check_val("t3_tready", int'(AXIS_TREADY), 1);
        check_val("t3_ml_1", int'(matrices_loaded), 1);
        @(posedge clk);
        #1;
        AXIS_TVALID      = 1'b0;
        compute_finished = 1'b0;
        check_val("t3_ml_0", int'(matrices_loaded), 0);
        @(posedge clk);
        #1;
        check_val("t3_ml_1b", int'(matrices_loaded), 1);
        check_val("t3_k", int'(K), 2);
        read_check("t3_set4", 3, 0, 203, 300);
        read_check("t3_set4b", 0, 17, 200, 317);
        pulse_cf();
        check_val("t3_pop_gap", int'(matrices_loaded), 0);
        @(posedge clk);
        #1;
        check_val("t3_empty", int'(matrices_loaded), 0);
        pulse_cf();

        // 4: K=8 with TVALID low every other cycle
        send_set(17, 1000, 0, 128, 1'b1, s);
        check_val("t4_no_stall", s, 0);
        check_val("t4_ml", int'(matrices_loaded), 1);
        check_val("t4_k", int'(K), 8);
        for (int i = 0; i < 72; i++) begin
            read_check("t4_rd", i % 56, i, 1000 + (i % 56), 1056 + i);
        end
        pulse_cf();
        @(posedge clk);
        #1;

        // 5: K clamping
        send_set(1, 500, 0, 16, 1'b0, s);
        check_val("t5_k0_ml", int'(matrices_loaded), 1);
        check_val("t5_k0_k", int'(K), 1);
        read_check("t5_k0_r", 6, 8, 506, 515);
        read_check("t5_k0_r0", 0, 0, 500, 507);
        pulse_cf();
        @(posedge clk);
        #1;
        send_set(25, 600, 0, 127, 1'b0, s);
        check_val("t5_k12_pre", int'(matrices_loaded), 0);
        send_set(25, 600, 127, 1, 1'b0, s);
        check_val("t5_k12_ml", int'(matrices_loaded), 1);
        check_val("t5_k12_k", int'(K), 8);
        read_check("t5_k12_r", 55, 71, 655, 727);
        pulse_cf();
        @(posedge clk);
        #1;

        // 6: reset in the middle of LOAD_A, then a fresh K=3 set
        send_set(5, 700, 0, 5, 1'b0, s);
        #1;
        reset = 1'b0;
        #1;
        check_val("t6_tready", int'(AXIS_TREADY), 0);
        check_val("t6_ml", int'(matrices_loaded), 0);
        check_val("t6_k", int'(K), 0);
        check_val("t6_adata", int'(A_data), 0);
        check_val("t6_bdata", int'(B_data), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_set(7, 800, 0, 47, 1'b0, s);
        check_val("t6_ml_pre", int'(matrices_loaded), 0);
        send_set(7, 800, 47, 1, 1'b0, s);
        check_val("t6_ml_post", int'(matrices_loaded), 1);
        check_val("t6_k3", int'(K), 3);
        read_check("t6_r0", 20, 26, 820, 847);
        read_check("t6_r1", 0, 0, 800, 821);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
